// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor slice per clock.
// A borrow flop chains the slices; a start/busy/done FSM sequences each operation.

module full_subtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);
   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_bout;
   logic             r_ovf;

   logic             w_d;
   logic             w_br;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;
   logic             w_unused_res_lsb;

   full_subtractor u_cell (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_br)
   );

   // Start is only honoured when no operation is in flight.
   assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_CNT);
   assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};
   // The oldest result bit falls off the shift register and is never needed.
   assign w_unused_res_lsb = r_res_sh[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = start ? SHIFT : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a_sh   <= a;
         r_b_sh   <= b;
         r_borrow <= bin;
         r_cnt    <= '0;
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
      end else if (r_state == SHIFT) begin
         r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
         r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
         r_res_sh <= w_res_next;
         r_borrow <= w_br;
         r_cnt    <= r_cnt + 1'b1;
         // Results are published only once the final slice is known.
         if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br;
            r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
         end
      end
   end

   assign busy = (r_state == SHIFT);
   assign done = (r_state == DONE);
   assign diff = r_diff;
   assign bout = r_bout;
   assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): results, latency, handshake,
// start-while-busy, back-to-back operation and asynchronous reset mid-operation.
module tb_serial_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int           checks = 0;
   int           errors = 0;
   int           dones;
   logic [W-1:0] last_diff;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete operation with a single-cycle start pulse.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, input logic [W-1:0] ed, input logic eb, input logic eo);
      @(negedge clk);
      a = ta; b = tb_; bin = tbin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ta; b = ~tb_;
      chk({tag, " busy@accept"}, busy, 1'b1);
      chk({tag, " done@accept"}, done, 1'b0);
      for (int i = 1; i <= W; i++) begin
         @(posedge clk); #1;
         if (i < W) chk({tag, " done early"}, done, 1'b0);
         if (i == W / 2) chk({tag, " diff held"}, diff, last_diff);
      end
      chk({tag, " done"}, done, 1'b1);
      chk({tag, " busy@done"}, busy, 1'b0);
      chk({tag, " diff"}, diff, ed);
      chk({tag, " bout"}, bout, eb);
      chk({tag, " ovf"}, ovf, eo);
      $display("op %s: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d",
               tag, ta, tb_, tbin, diff, bout, ovf);
      last_diff = ed;
      @(posedge clk); #1;
      chk({tag, " done falls"}, done, 1'b0);
      chk({tag, " idle"}, busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      last_diff = '0;
      #2;
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst diff", diff, 8'h00);
      chk("rst bout", bout, 1'b0);
      chk("rst ovf",  ovf,  1'b0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      run_op("basic",   8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
      run_op("under",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("bin",     8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

      // start pulsed mid-SHIFT with other operands must be ignored
      @(negedge clk);
      a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0;
      for (int i = 1; i <= W + 2; i++) begin
         @(posedge clk); #1;
         if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
         if (i == 4) start = 1'b0;
         if (done) dones++;
         if (i == W) begin
            chk("midstart done", done, 1'b1);
            chk("midstart diff", diff, 8'h30);
            chk("midstart bout", bout, 1'b0);
            $display("op midstart: a=50 b=20 bin=0 -> diff=%02h bout=%0d ovf=%0d", diff, bout, ovf);
         end
      end
      chk("midstart one done", dones, 1);
      last_diff = 8'h30;

      // back-to-back: start held through DONE accepts the next pair
      @(negedge clk);
      a = 8'h20; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < W; i++) begin
         @(posedge clk); #1;
      end
      a = 8'h09; b = 8'h03; start = 1'b1;
      @(posedge clk); #1;
      chk("b2b first done", done, 1'b1);
      chk("b2b first diff", diff, 8'h1F);
      $display("op b2b_first: a=20 b=01 bin=0 -> diff=%02h bout=%0d ovf=%0d", diff, bout, ovf);
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b no idle", busy, 1'b1);
      chk("b2b done falls", done, 1'b0);
      for (int j = 1; j <= W; j++) begin
         @(posedge clk); #1;
         if (j == W) begin
            chk("b2b second done", done, 1'b1);
            chk("b2b second diff", diff, 8'h06);
            chk("b2b second bout", bout, 1'b0);
            chk("b2b second ovf",  ovf,  1'b0);
            $display("op b2b_second: a=09 b=03 bin=0 -> diff=%02h bout=%0d ovf=%0d", diff, bout, ovf);
         end
      end

      // asynchronous reset in the middle of SHIFT
      @(negedge clk);
      a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", busy, 1'b0);
      chk("async rst done", done, 1'b0);
      chk("async rst diff", diff, 8'h00);
      chk("async rst bout", bout, 1'b0);
      chk("async rst ovf",  ovf,  1'b0);
      $display("op abort: a=AA b=55 reset mid-shift -> diff=%02h busy=%0d", diff, busy);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      chk("abort no done", dones, 0);
      last_diff = 8'h00;
      run_op("post_rst", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
